// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Bundle of N requester streams plus the single arbitrated output stream.
interface rr_stream_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  // master: the environment (requesters + downstream); slave: the arbiter
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Circular priority picker: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IDW = $clog2(N);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_valid && req[(32'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-to-1 packet-locked round-robin arbiter feeding one registered valid/ready stage.
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
) (
  input logic                clk,
  input logic                reset,
  rr_stream_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [IDW-1:0]   out_id_q;

  logic             load_en;
  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_idx;
  logic             ready_en;
  logic             xfer;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;
  logic [WIDTH-1:0] data_arr [N];

  rr_priority_pick #(
    .N(N)
  ) u_pick (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      data_arr[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en   = !out_valid_q || bus.out_ready;
  // A locked owner keeps the grant even while it idles between beats.
  assign gnt_valid = (state_q == ARB_LOCKED) || pick_valid;
  assign gnt_idx   = (state_q == ARB_LOCKED) ? lock_id_q : pick_idx;
  assign ready_en  = load_en && gnt_valid && !reset;
  assign xfer      = ready_en && bus.in_valid[gnt_idx];
  assign beat_data = data_arr[gnt_idx];
  assign beat_last = bus.in_last[gnt_idx];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:   if (xfer && !beat_last) state_d = ARB_LOCKED;
      ARB_LOCKED: if (xfer && beat_last)  state_d = ARB_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready = '0;
    if (ready_en) begin
      bus.in_ready[gnt_idx] = 1'b1;
    end
  end

  // Pointer only advances at packet end, so a locked owner cannot be skipped.
  always_comb begin
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (xfer) begin
      if (beat_last) begin
        rr_ptr_d = IDW'(rr_next(32'(gnt_idx), N));
      end else begin
        lock_id_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_last_q  <= beat_last;
        out_id_q    <= gnt_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (N=4) with a per-beat ordering scoreboard.
module tb_rr_stream_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pdata [4];
  logic [63:0] sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  rr_stream_arbiter_if #(.WIDTH(32), .N(4)) bus ();

  rr_stream_arbiter #(
    .WIDTH(32),
    .N    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.in_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Accepted beats must leave the output register once each, in acceptance order.
  always @(negedge clk) begin
    check("ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'd1);
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          check("sb_beat", {29'b0, bus.out_last, bus.out_id, bus.out_data}, sb.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          sb.push_back({29'b0, bus.in_last[i], 2'(i), pdata[i]});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) pdata[i] = 32'hA000_0000 + 32'(i);
    reset         = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_last   = 4'hF;
    bus.out_ready = 1'b1;

    // Reset with every requester active
    repeat (2) begin
      cycle();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_id", bus.out_id, 0);
    end
    check("rst_out_data", bus.out_data, 0);
    reset = 1'b0;
    #1 check("first_grant", bus.in_ready, 4'b0001);

    // Fairness over single-beat packets
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("fair_valid", bus.out_valid, 1);
      check("fair_id", bus.out_id, 64'(k % 4));
      check("fair_data", bus.out_data, 64'(32'hA000_0000 + 32'(k % 4)));
      #1 check("fair_ready", bus.in_ready, 64'(1 << ((k + 1) % 4)));
    end
    bus.in_valid = 4'b0000;
    cycle();
    check("fair_drain", bus.out_valid, 0);

    // Lock: port 2 three beats with a gap, port 0 waiting
    pdata[2]     = 32'h2222_0001;
    bus.in_last  = 4'b1011;
    bus.in_valid = 4'b0101;
    #1 check("lock_first", bus.in_ready, 4'b0100);
    cycle();
    check("lock_b1_id", bus.out_id, 2);
    check("lock_b1_data", bus.out_data, 32'h2222_0001);
    check("lock_b1_last", bus.out_last, 0);
    bus.in_valid = 4'b0001;
    #1 check("lock_gap_ready", bus.in_ready, 4'b0100);
    cycle();
    check("lock_gap_valid", bus.out_valid, 0);
    pdata[2]     = 32'h2222_0002;
    bus.in_valid = 4'b0101;
    #1 check("lock_b2_ready", bus.in_ready, 4'b0100);
    cycle();
    check("lock_b2_id", bus.out_id, 2);
    check("lock_b2_data", bus.out_data, 32'h2222_0002);
    pdata[2]    = 32'h2222_0003;
    bus.in_last = 4'b1111;
    #1 check("lock_b3_ready", bus.in_ready, 4'b0100);
    cycle();
    check("lock_b3_id", bus.out_id, 2);
    check("lock_b3_last", bus.out_last, 1);
    #1 check("unlock_ready", bus.in_ready, 4'b0001);
    cycle();
    check("unlock_id", bus.out_id, 0);
    bus.in_valid = 4'b0000;

    // Backpressure
    pdata[1]     = 32'hDEAD_BEEF;
    bus.in_valid = 4'b0010;
    #1 check("bp_grant", bus.in_ready, 4'b0010);
    cycle();
    check("bp_load_data", bus.out_data, 32'hDEAD_BEEF);
    check("bp_load_id", bus.out_id, 1);
    bus.out_ready = 1'b0;
    pdata[1]      = 32'h1111_1111;
    bus.in_valid  = 4'b0110;
    #1 check("bp_ready", bus.in_ready, 0);
    repeat (3) begin
      cycle();
      check("bp_hold_data", bus.out_data, 32'hDEAD_BEEF);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0000;
    cycle();
    check("bp_drain", bus.out_valid, 0);

    // Reset in the middle of a port-3 packet
    pdata[3]     = 32'h3333_0001;
    bus.in_last  = 4'b0111;
    bus.in_valid = 4'b1000;
    #1 check("mid_grant", bus.in_ready, 4'b1000);
    cycle();
    check("mid_id", bus.out_id, 3);
    check("mid_last", bus.out_last, 0);
    bus.in_valid = 4'b1001;
    reset        = 1'b1;
    #1 check("mid_rst_ready", bus.in_ready, 0);
    cycle();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    reset = 1'b0;
    #1 check("post_rst_grant", bus.in_ready, 4'b0001);
    cycle();
    check("post_rst_id", bus.out_id, 0);
    bus.in_valid = 4'b0000;

    // Wrap: advance rr_ptr to 3, then ports 3 and 0 alternate
    bus.in_last  = 4'b1111;
    bus.in_valid = 4'b0100;
    cycle();
    check("wrap_pre_id", bus.out_id, 2);
    bus.in_valid = 4'b1001;
    #1 check("wrap_first", bus.in_ready, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("wrap_id", bus.out_id, (k % 2 == 0) ? 64'd3 : 64'd0);
    end
    bus.in_valid = 4'b0000;
    cycle();
    check("wrap_drain", bus.out_valid, 0);
    cycle();
    check("sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
